// File: rtl/serial_pattern_gen.sv
// Serial pattern transmitter: shifts a captured pattern out MSB-first on w.
// Optional PATGEN_LOOP_EN adds a Loop input that resends the frame after the gap.
module serial_pattern_gen #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4,
  parameter int GAP   = 2
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             Start,
  input  logic             Abort,
  input  logic [WIDTH-1:0] Pattern,
  input  logic [LEN_W-1:0] Length,
`ifdef PATGEN_LOOP_EN
  input  logic             Loop,
`endif
  output logic             w,
  output logic             Valid,
  output logic             Busy,
  output logic             Done,
  output logic [1:0]       CurState
);

  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    GAPS  = 2'b10,
    DONE  = 2'b11
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic [LEN_W-1:0] leff;
  logic [LEN_W-1:0] shamt;
  logic             gap_last;
  logic             loop_done;

`ifdef PATGEN_LOOP_EN
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d;
`endif

  always_comb begin
    leff  = (Length > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : Length;
    shamt = LEN_W'(WIDTH) - leff;
  end

  assign gap_last = (gap_q == GW'(GAP - 1));

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
`ifdef PATGEN_LOOP_EN
    pat_d   = pat_q;
    len_d   = len_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (Start && !Abort) begin
          // left-align so the active field's MSB sits at the top
          sh_d    = Pattern << shamt;
          cnt_d   = leff;
          gap_d   = '0;
          state_d = (leff == '0) ? DONE : SHIFT;
`ifdef PATGEN_LOOP_EN
          pat_d   = Pattern << shamt;
          len_d   = leff;
`endif
        end
      end
      SHIFT: begin
        sh_d  = {sh_q[WIDTH-2:0], 1'b0};
        cnt_d = cnt_q - LEN_W'(1);
        if (cnt_q == LEN_W'(1)) begin
          state_d = GAPS;
          gap_d   = '0;
        end
      end
      GAPS: begin
        gap_d = gap_q + GW'(1);
        if (gap_last) begin
          gap_d   = '0;
          state_d = DONE;
`ifdef PATGEN_LOOP_EN
          if (Loop) begin
            state_d = SHIFT;
            sh_d    = pat_q;
            cnt_d   = len_q;
          end
`endif
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (Abort && state_q != IDLE) begin
      state_d = IDLE;
      sh_d    = '0;
      cnt_d   = '0;
      gap_d   = '0;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
`ifdef PATGEN_LOOP_EN
      pat_q   <= '0;
      len_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
`ifdef PATGEN_LOOP_EN
      pat_q   <= pat_d;
      len_q   <= len_d;
`endif
    end
  end

`ifdef PATGEN_LOOP_EN
  assign loop_done = (state_q == GAPS) && gap_last && Loop && !Abort;
`else
  assign loop_done = 1'b0;
`endif

  assign w        = (state_q == SHIFT) && sh_q[WIDTH-1];
  assign Valid    = (state_q == SHIFT);
  assign Busy     = (state_q == SHIFT) || (state_q == GAPS);
  assign Done     = (state_q == DONE) || loop_done;
  assign CurState = state_q;

endmodule
